// File: rtl/call_stack_pkg.sv
// Shared CPU datapath constants used by the return-address stack and its neighbours.
package cpu_pkg;

    localparam int ADDR_W = 19;

    localparam logic [4:0] OP_CALL = 5'b01110;
    localparam logic [4:0] OP_RET  = 5'b10001;

    // PC-mux select that routes the stack top into the program counter.
    localparam logic [1:0] JMP_SEL_STACK = 2'b11;

endpackage

// File: rtl/call_stack_if.sv
// Decoder-to-stack strobe/status bundle; the stack is the slave side.
interface call_stack_if #(
    parameter int DEPTH = 16
);
    localparam int PTR_W = $clog2(DEPTH);

    // push/pop are single-cycle strobes that take effect only on an edge where en=1;
    // there is no back-pressure, so errors are reported through the sticky flags instead.
    logic                      en;
    logic                      push;
    logic                      pop;
    logic [cpu_pkg::ADDR_W-1:0] pc;
    logic                      clr_err;
    logic [cpu_pkg::ADDR_W-1:0] ret_addr;
    logic                      empty;
    logic                      full;
    logic [PTR_W:0]            count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output en, push, pop, pc, clr_err,
        input  ret_addr, empty, full, count, overflow, underflow
    );

    modport slave (
        input  en, push, pop, pc, clr_err,
        output ret_addr, empty, full, count, overflow, underflow
    );

endinterface

// File: rtl/call_stack_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read port, no reset.
module call_stack_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack fed by the decoder's call/return strobes.
// Define CALL_STACK_WRAP_EN to overwrite the oldest entry on push-while-full.
module call_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    call_stack_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] SP_ONE   = PTR_W'(1);

    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_en;
    logic [PTR_W-1:0]  wr_addr;
    logic [PTR_W-1:0]  top_addr;
    logic [ADDR_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_data;
    logic              empty;
    logic              full;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign top_addr = sp_q - SP_ONE;
    assign wr_data  = bus.pc + ADDR_W'(1);

    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        overflow_d  = bus.clr_err ? 1'b0 : overflow_q;
        underflow_d = bus.clr_err ? 1'b0 : underflow_q;
        wr_en       = 1'b0;
        wr_addr     = sp_q;
        if (bus.en) begin
            if (bus.push && bus.pop && !empty) begin
                // Simultaneous call/return replaces the top entry in place.
                wr_en   = 1'b1;
                wr_addr = top_addr;
            end else if (bus.push) begin
                if (!full) begin
                    wr_en   = 1'b1;
                    sp_d    = sp_q + SP_ONE;
                    count_d = count_q + CNT_ONE;
                end else begin
                    overflow_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                    wr_en = 1'b1;
                    sp_d  = sp_q + SP_ONE;
`endif
                end
            end else if (bus.pop) begin
                if (!empty) begin
                    sp_d    = top_addr;
                    count_d = count_q - CNT_ONE;
                end else begin
                    underflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    call_stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (top_addr),
        .rd_data (rd_data)
    );

    assign bus.ret_addr  = empty ? '0 : rd_data;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: vector table plus hand-written fill/drain and reset sequences.
module tb_call_stack;
    import cpu_pkg::*;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic        en;
        logic        push;
        logic        pop;
        logic        clr;
        logic [18:0] pc;
        logic [4:0]  cnt;
        logic [18:0] ret;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    call_stack_if #(.DEPTH(DEPTH)) bus();

    call_stack #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] pack(input logic [4:0] cnt, input logic emp, input logic ful,
                                         input logic ovf, input logic unf, input logic [18:0] ret);
        return {4'b0, cnt, emp, ful, ovf, unf, ret};
    endfunction

    function automatic logic [31:0] obs();
        return pack(bus.count, bus.empty, bus.full, bus.overflow, bus.underflow, bus.ret_addr);
    endfunction

    function automatic vec_t mk(input logic en, input logic push, input logic pop, input logic clr,
                                input logic [18:0] pc, input logic [4:0] cnt, input logic [18:0] ret,
                                input logic emp, input logic ful, input logic ovf, input logic unf);
        vec_t v;
        v = {en, push, pop, clr, pc, cnt, ret, emp, ful, ovf, unf};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {cnt,emp,ful,ovf,unf,ret}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic push, input logic pop, input logic clr,
                         input logic [18:0] pc);
        bus.en      = en;
        bus.push    = push;
        bus.pop     = pop;
        bus.clr_err = clr;
        bus.pc      = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [18:0] exp_ret;
        logic [4:0]  exp_cnt;

        // Reset block
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 19'h0);
        #12;
        check("reset_state", obs(), pack(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0));
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: inputs applied for one edge, outputs checked #1 after it.
        //            en push pop clr pc         cnt ret        emp ful ovf unf
        vecs.push_back(mk(1, 0, 0, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 19'h00010, 1, 19'h00011, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 19'h00200, 2, 19'h00201, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 19'h00000, 1, 19'h00011, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 19'h7FFFF, 1, 19'h00000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 19'h00000, 0, 19'h00000, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 19'h00000, 0, 19'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 19'h00123, 0, 19'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 19'h00123, 0, 19'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 19'h00123, 0, 19'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 19'h00010, 1, 19'h00011, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 19'h00500, 1, 19'h00501, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 19'h00040, 1, 19'h00041, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 19'h00000, 1, 19'h00041, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 19'h00000, 0, 19'h00000, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].pc);
            tick();
            exp_q.push_back(pack(vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf,
                                 vecs[i].ret));
            check($sformatf("vec%0d", i), obs(), exp_q.pop_front());
        end

        // DEPTH+1 pushes of pc=k: the last one hits a full stack.
        for (int k = 0; k <= DEPTH; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 19'(k));
            tick();
            exp_cnt = (k < DEPTH) ? 5'(k + 1) : 5'(DEPTH);
`ifdef CALL_STACK_WRAP_EN
            exp_ret = 19'(k + 1);
`else
            exp_ret = (k < DEPTH) ? 19'(k + 1) : 19'(DEPTH);
`endif
            check($sformatf("fill%0d", k), obs(),
                  pack(exp_cnt, 1'b0, (k >= DEPTH - 1), (k == DEPTH), 1'b0, exp_ret));
        end

        // Drain: ret_addr is checked combinationally before each popping edge.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 19'h0);
            #1;
`ifdef CALL_STACK_WRAP_EN
            exp_ret = 19'(DEPTH + 1 - i);
`else
            exp_ret = 19'(DEPTH - i);
`endif
            check($sformatf("drain%0d", i), obs(),
                  pack(5'(DEPTH - i), 1'b0, (i == 0), 1'b1, 1'b0, exp_ret));
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 19'h0);
        #1;
        check("drained", obs(), pack(5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 19'h0));
        drive(1'b1, 1'b0, 1'b0, 1'b1, 19'h0);
        tick();
        check("clr_ovf", obs(), pack(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0));

        // Asynchronous reset between clock edges discards the entries at once.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 19'h00010);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 19'h00020);
        tick();
        check("pre_reset", obs(), pack(5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 19'h00021));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 19'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", obs(), pack(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset", obs(), pack(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
